// File: rtl/bnn_pkg.sv
// Shared types and constants for the binary conv layer control path.
package bnn_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_CLEAR,
    SEQ_RUN,
    SEQ_DONE
  } seq_state_t;

  // A 3x3 kernel has nine binary taps per input channel.
  localparam int KERNEL_TAPS = 9;

endpackage

// File: rtl/conv_layer_sequencer.sv
// Initiator side of the binary conv-core handshake. Runs one layer as OC
// sequential core passes, presenting each output channel's kernel, raising
// go (conv_data_in_ready), waiting for the core's done pulse and capturing
// the resulting map into fmap_out[oc].
module conv_layer_sequencer
  import bnn_pkg::*;
#(
  parameter int IC            = 8,
  parameter int OC            = 8,
  parameter int IMG_OUT_SIZE  = 28,
  parameter int TIMEOUT_SLACK = 4
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         start,
  output logic                                         busy,
  input  logic [OC*IC*KERNEL_TAPS-1:0]                 weights_all,
  output logic                                         conv_data_in_ready,
  output logic [IC*KERNEL_TAPS-1:0]                    conv_weights,
  input  logic [IMG_OUT_SIZE*IMG_OUT_SIZE-1:0]         conv_img_out,
  input  logic                                         conv_data_out_ready,
  output logic [0:OC-1][IMG_OUT_SIZE*IMG_OUT_SIZE-1:0] fmap_out,
  output logic                                         fmap_valid,
  input  logic                                         fmap_ack,
  output logic                                         timeout_err
);

  localparam int KW       = IC * KERNEL_TAPS;
  localparam int OC_W     = (OC > 1) ? $clog2(OC) : 1;
  localparam int TC_W     = $clog2(IC + TIMEOUT_SLACK + 1);
  localparam int TC_LIMIT = IC + TIMEOUT_SLACK;

  seq_state_t        state, state_nxt;
  logic [OC_W-1:0]   oc, oc_nxt;
  logic [TC_W-1:0]   tcnt, tcnt_nxt;
  logic              go_nxt;
  logic [KW-1:0]     weights_nxt;
  logic [KW-1:0]     kernel_sel;
  logic              valid_nxt;
  logic              terr_nxt;
  logic              capture;

  assign busy = (state != SEQ_IDLE);

  // Kernel slice for the current output channel (constant-index mux).
  always_comb begin
    kernel_sel = '0;
    for (int i = 0; i < OC; i++) begin
      if (oc == OC_W'(i)) kernel_sel = weights_all[i*KW +: KW];
    end
  end

  // Next-state and next-output logic; done on the same cycle as the timeout wins.
  always_comb begin
    state_nxt   = state;
    oc_nxt      = oc;
    tcnt_nxt    = tcnt;
    go_nxt      = conv_data_in_ready;
    weights_nxt = conv_weights;
    valid_nxt   = fmap_valid;
    terr_nxt    = timeout_err;
    capture     = 1'b0;
    case (state)
      SEQ_IDLE: begin
        if (start) begin
          state_nxt = SEQ_CLEAR;
          oc_nxt    = '0;
          terr_nxt  = 1'b0;
        end
      end
      SEQ_CLEAR: begin
        // go is low for this cycle so the core restarts its counters.
        weights_nxt = kernel_sel;
        go_nxt      = 1'b1;
        tcnt_nxt    = '0;
        state_nxt   = SEQ_RUN;
      end
      SEQ_RUN: begin
        if (conv_data_out_ready) begin
          capture = 1'b1;
          go_nxt  = 1'b0;
          if (oc == OC_W'(OC - 1)) begin
            state_nxt = SEQ_DONE;
            valid_nxt = 1'b1;
          end else begin
            oc_nxt    = oc + 1'b1;
            state_nxt = SEQ_CLEAR;
          end
        end else if (tcnt == TC_W'(TC_LIMIT)) begin
          go_nxt    = 1'b0;
          terr_nxt  = 1'b1;
          state_nxt = SEQ_IDLE;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      SEQ_DONE: begin
        if (fmap_ack) begin
          valid_nxt = 1'b0;
          state_nxt = SEQ_IDLE;
        end
      end
      default: state_nxt = SEQ_IDLE;
    endcase
  end

  // Control and registered-output state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= SEQ_IDLE;
      oc                 <= '0;
      tcnt               <= '0;
      conv_data_in_ready <= 1'b0;
      conv_weights       <= '0;
      fmap_valid         <= 1'b0;
      timeout_err        <= 1'b0;
    end else begin
      state              <= state_nxt;
      oc                 <= oc_nxt;
      tcnt               <= tcnt_nxt;
      conv_data_in_ready <= go_nxt;
      conv_weights       <= weights_nxt;
      fmap_valid         <= valid_nxt;
      timeout_err        <= terr_nxt;
    end
  end

  // Capture the core's map into the slot of the channel just finished.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fmap_out <= '0;
    end else if (capture) begin
      for (int i = 0; i < OC; i++) begin
        if (oc == OC_W'(i)) fmap_out[i] <= conv_img_out;
      end
    end
  end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Scoreboard bench for conv_layer_sequencer with a behavioural conv-core model.
module tb_conv_layer_sequencer;
  localparam int IC    = 2;
  localparam int OC    = 3;
  localparam int IMG   = 4;
  localparam int SLACK = 4;
  localparam int MW    = IMG * IMG;
  localparam int KW    = IC * 9;
  localparam logic [MW-1:0] FIX [OC] = '{16'hA5A5, 16'h0F0F, 16'hFFFF};

  typedef struct {
    bit                     is_to;
    int                     lat;
    int                     t0;
    logic [OC-1:0][MW-1:0]  maps;
  } exp_t;

  logic clk, rst_n, start, busy, go, core_done, spur, fmap_valid, fmap_ack, timeout_err;
  logic [OC*KW-1:0]         weights_all;
  logic [KW-1:0]            conv_weights;
  logic [MW-1:0]            core_map;
  logic [0:OC-1][MW-1:0]    fmap_out;
  logic                     conv_data_out_ready;

  logic start1, busy1, go1, done1, fmap_valid1, fmap_ack1, terr1;
  logic [KW-1:0]            weights1, conv_weights1;
  logic [MW-1:0]            map1;
  logic [0:0][MW-1:0]       fmap_out1;
  int                       c1;

  logic [MW-1:0] cur_maps [OC];
  logic [MW-1:0] mdl_fmap [OC];
  int            hang_pass;
  int            go_cnt, pass_idx;
  logic          go_q;
  int            cyc;
  int            n_cmp, n_fail;
  exp_t          exp_q[$];

  assign conv_data_out_ready = core_done | spur;

  conv_layer_sequencer #(.IC(IC), .OC(OC), .IMG_OUT_SIZE(IMG), .TIMEOUT_SLACK(SLACK)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .weights_all(weights_all),
    .conv_data_in_ready(go), .conv_weights(conv_weights), .conv_img_out(core_map),
    .conv_data_out_ready(conv_data_out_ready), .fmap_out(fmap_out), .fmap_valid(fmap_valid),
    .fmap_ack(fmap_ack), .timeout_err(timeout_err));

  conv_layer_sequencer #(.IC(IC), .OC(1), .IMG_OUT_SIZE(IMG), .TIMEOUT_SLACK(SLACK)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .weights_all(weights1),
    .conv_data_in_ready(go1), .conv_weights(conv_weights1), .conv_img_out(map1),
    .conv_data_out_ready(done1), .fmap_out(fmap_out1), .fmap_valid(fmap_valid1),
    .fmap_ack(fmap_ack1), .timeout_err(terr1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Core model: done pulses IC+1 edges after go rises; the pass numbered hang_pass never finishes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go_cnt <= 0; core_done <= 1'b0; core_map <= '0; go_q <= 1'b0; pass_idx <= -1;
    end else begin
      go_q <= go;
      if (!busy) pass_idx <= -1;
      else if (go && !go_q) pass_idx <= pass_idx + 1;
      if (go) begin
        go_cnt <= go_cnt + 1;
        if (go_cnt + 1 == IC + 1 && pass_idx != hang_pass && pass_idx >= 0 && pass_idx < OC) begin
          core_done <= 1'b1;
          core_map  <= cur_maps[pass_idx];
        end else begin
          core_done <= 1'b0;
        end
      end else begin
        go_cnt <= 0; core_done <= 1'b0;
      end
    end
  end

  // Core model for the single-channel instance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c1 <= 0; done1 <= 1'b0;
    end else if (go1) begin
      c1 <= c1 + 1; done1 <= (c1 + 1 == IC + 1);
    end else begin
      c1 <= 0; done1 <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_fmap(input string nm);
    for (int i = 0; i < OC; i++) chk(nm, 64'(fmap_out[i]), 64'(mdl_fmap[i]));
  endtask

  task automatic monitor();
    logic vprev = 1'b0, tprev = 1'b0, gprev = 1'b0;
    int   rise_n = 0, low_n = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        vprev = 1'b0; tprev = 1'b0; gprev = 1'b0; rise_n = 0; low_n = 0;
        continue;
      end
      if (!busy) begin rise_n = 0; low_n = 0; end
      if (go && !gprev) begin
        rise_n++;
        if (rise_n > 1) chk("go_low_gap", 64'(low_n), 64'd1);
        low_n = 0;
      end
      if (busy && !go) low_n++;
      if (go && rise_n >= 1 && rise_n <= OC)
        chk("conv_weights", 64'(conv_weights), 64'(weights_all[(rise_n-1)*KW +: KW]));
      if ((fmap_valid && !vprev) || (timeout_err && !tprev)) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_result: valid=%0b terr=%0b with nothing expected", fmap_valid, timeout_err);
        end else begin
          e = exp_q.pop_front();
          chk("result_valid", 64'(fmap_valid), 64'(!e.is_to));
          chk("result_terr", 64'(timeout_err), 64'(e.is_to));
          chk("latency", 64'(cyc - e.t0), 64'(e.lat));
          for (int i = 0; i < OC; i++) chk("fmap_out", 64'(fmap_out[i]), 64'(e.maps[i]));
        end
      end
      vprev = fmap_valid; tprev = timeout_err; gprev = go;
    end
  endtask

  // Issue one layer; the expectation comes from plain pass arithmetic.
  task automatic run_layer(input int hang, input bit fixed, input bit noisy, input bit push);
    logic [63:0] tmp;
    exp_t e;
    int k;
    tmp = {$urandom(), $urandom()};
    weights_all = tmp[OC*KW-1:0];
    for (int i = 0; i < OC; i++) cur_maps[i] = fixed ? FIX[i] : MW'($urandom());
    hang_pass = hang;
    if (push) begin
      e.is_to = (hang >= 0);
      for (int i = 0; i < OC; i++) begin
        if (hang < 0 || i < hang) mdl_fmap[i] = cur_maps[i];
        e.maps[i] = mdl_fmap[i];
      end
      e.lat = (hang < 0) ? OC * (IC + 3) + 1 : hang * (IC + 3) + 1 + 1 + (IC + SLACK + 1);
      e.t0  = cyc;
      exp_q.push_back(e);
    end
    start = 1'b1;
    @(negedge clk); start = 1'b0; spur = noisy;
    @(negedge clk); spur = 1'b0; start = noisy;
    @(negedge clk); start = 1'b0;
    if (!push) return;
    for (k = 0; k < 200; k++) begin
      if (fmap_valid || (timeout_err && !busy)) break;
      @(negedge clk);
    end
    if (k == 200) begin
      n_cmp++; n_fail++;
      $display("FAIL run_wait: no result within 200 cycles");
    end
  endtask

  task automatic ack_layer(input int d);
    repeat (d) @(negedge clk);
    fmap_ack = 1'b1;
    @(negedge clk); fmap_ack = 1'b0;
    chk("ack_busy", 64'(busy), 64'd0);
    chk("ack_valid", 64'(fmap_valid), 64'd0);
  endtask

  task automatic stimulus();
    int k, t, h;
    logic [63:0] tmp;
    // Reset in the middle of pass 1.
    run_layer(-1, 1'b0, 1'b0, 1'b0);
    for (k = 0; k < 50; k++) begin
      if (pass_idx == 1 && go) break;
      @(negedge clk);
    end
    chk("reach_pass1", 64'(k < 50), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_go", 64'(go), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(fmap_valid), 64'd0);
    for (int i = 0; i < OC; i++) mdl_fmap[i] = '0;
    chk_fmap("rst_fmap");
    @(negedge clk); #1 rst_n = 1'b1;
    @(negedge clk);

    // Fixed maps, then hold off the ack with a stray start.
    run_layer(-1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = (i == 4);
      chk("hold_valid", 64'(fmap_valid), 64'd1);
      chk_fmap("hold_fmap");
    end
    start = 1'b0;
    ack_layer(0);
    @(negedge clk);
    chk("start_in_done_ignored", 64'(busy), 64'd0);

    // Hang on pass 1, then a clean layer.
    run_layer(1, 1'b0, 1'b0, 1'b1);
    chk("to_go", 64'(go), 64'd0);
    chk("to_busy", 64'(busy), 64'd0);
    @(negedge clk);
    run_layer(-1, 1'b0, 1'b0, 1'b1);
    ack_layer(1);

    // Spurious done while idle.
    spur = 1'b1;
    @(negedge clk); spur = 1'b0;
    @(negedge clk);
    chk("spur_idle_busy", 64'(busy), 64'd0);
    chk_fmap("spur_idle_fmap");

    // Spurious done in CLEAR and start during RUN.
    run_layer(-1, 1'b0, 1'b1, 1'b1);
    ack_layer(2);

    // Random layers with occasional hangs.
    for (int r = 0; r < 8; r++) begin
      h = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, OC - 1)) : -1;
      run_layer(h, 1'b0, 1'b0, 1'b1);
      if (h < 0) ack_layer(int'($urandom_range(0, 3)));
      else @(negedge clk);
    end

    // Single-channel build.
    tmp = {$urandom(), $urandom()};
    weights1 = tmp[KW-1:0];
    map1 = MW'($urandom());
    start1 = 1'b1; t = cyc;
    @(negedge clk); start1 = 1'b0;
    for (k = 0; k < 50; k++) begin
      if (fmap_valid1) break;
      @(negedge clk);
    end
    chk("oc1_latency", 64'(cyc - t), 64'(1 * (IC + 3) + 1));
    chk("oc1_fmap", 64'(fmap_out1[0]), 64'(map1));
    chk("oc1_weights", 64'(conv_weights1), 64'(weights1));
    fmap_ack1 = 1'b1;
    @(negedge clk); fmap_ack1 = 1'b0;
    chk("oc1_idle", 64'(busy1), 64'd0);
    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0;
    rst_n = 1'b0; start = 1'b0; spur = 1'b0; fmap_ack = 1'b0; hang_pass = -1;
    start1 = 1'b0; fmap_ack1 = 1'b0; weights1 = '0; map1 = '0; weights_all = '0;
    for (int i = 0; i < OC; i++) begin cur_maps[i] = '0; mdl_fmap[i] = '0; end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_go", 64'(go), 64'd0);
    chk("reset_valid", 64'(fmap_valid), 64'd0);
    chk("reset_terr", 64'(timeout_err), 64'd0);
    chk("reset_weights", 64'(conv_weights), 64'd0);
    chk_fmap("reset_fmap");
    fork
      monitor();
      stimulus();
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
